lfsr_stream: RTL and testbench

//  Parametrised Fibonacci-style LFSR pseudo-random source with a valid/ready stream output.

---
 rtl/lfsr_stream.sv | 86 ++++++++
 tb/tb_lfsr_stream.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_stream.sv
// lfsr_stream: parametrised Fibonacci LFSR exposed as a valid/ready word stream.
// The state register is the output word. STEP single-bit shifts are chained
// combinationally per advance. A runtime seed can be loaded at any time, and
// an all-zero state (which the LFSR could never leave) is replaced by SEED.
module lfsr_stream #(
  parameter int          WIDTH    = 32,
  parameter logic [63:0] TAPS     = 64'h0000_0000_088C_8892,
  parameter logic [63:0] SEED     = 64'd1331166,
  parameter int          STEP     = 1,
  parameter int          FREE_RUN = 0
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] seed_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             lockup_o
);

  localparam logic [WIDTH-1:0] TAPS_W = TAPS[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SEED_W = SEED[WIDTH-1:0];

  // Reject configurations that cannot produce a usable sequence.
  if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
    $error("lfsr_stream: WIDTH must be in 2..64");
  end
  if (SEED_W == '0) begin : g_bad_seed
    $error("lfsr_stream: SEED truncated to WIDTH must be nonzero");
  end
  if (STEP < 1 || STEP > WIDTH) begin : g_bad_step
    $error("lfsr_stream: STEP must be in 1..WIDTH");
  end

  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] stepped;
  logic [WIDTH-1:0] cand;
  logic             valid;
  logic             adv;
  logic             write;
  logic             zero_hit;

  // Chain STEP single-bit shifts so one advance costs one cycle.
  always_comb begin
    stepped = state;
    for (int i = 0; i < STEP; i++) begin
      stepped = {stepped[WIDTH-2:0], ^(stepped & TAPS_W)};
    end
  end

  // In handshake mode only a word the consumer actually took moves the state.
  assign adv = (FREE_RUN != 0) ? en_i : (en_i & valid & ready_i);

  // Select the next value: load beats advance beats hold; flag an all-zero write.
  always_comb begin
    cand     = state;
    write    = 1'b0;
    if (load_i) begin
      cand  = seed_i;
      write = 1'b1;
    end else if (adv) begin
      cand  = stepped;
      write = 1'b1;
    end
    zero_hit = write && (cand == '0);
  end

  // State, valid and lock-up pulse registers; reset restarts from SEED.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state    <= SEED_W;
      valid    <= 1'b0;
      lockup_o <= 1'b0;
    end else begin
      state    <= zero_hit ? SEED_W : cand;
      valid    <= en_i;
      lockup_o <= zero_hit;
    end
  end

  assign data_o  = state;
  assign valid_o = valid;

endmodule

// File: tb/tb_lfsr_stream.sv
// Testbench for lfsr_stream: directed scenarios plus a randomized run, each
// cycle compared against a word-level reference model kept in the bench.
module tb_lfsr_stream;

  localparam logic [31:0] TAPS = 32'h088C_8892;
  localparam logic [31:0] SEED = 32'd1331166;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        en_i, load_i, ready_i;
  logic [31:0] seed_i;
  logic        valid_o, lockup_o;
  logic [31:0] data_o;

  logic        en4, load4, ready4;
  logic [31:0] seed4;
  logic        valid4, lock4;
  logic [31:0] data4;

  int total = 0;
  int bad   = 0;

  // Reference model of the STEP=1 handshake instance.
  logic [31:0] m_state;
  logic        m_valid;
  logic        m_lock;

  logic [31:0] q [0:4000];

  always #5 clk_i = ~clk_i;

  lfsr_stream dut (
    .clk_i(clk_i), .reset_i(reset_i), .en_i(en_i), .load_i(load_i),
    .seed_i(seed_i), .ready_i(ready_i), .valid_o(valid_o),
    .data_o(data_o), .lockup_o(lockup_o)
  );

  lfsr_stream #(.STEP(4)) dut4 (
    .clk_i(clk_i), .reset_i(reset_i), .en_i(en4), .load_i(load4),
    .seed_i(seed4), .ready_i(ready4), .valid_o(valid4),
    .data_o(data4), .lockup_o(lock4)
  );

  // n single-bit shifts: feedback is the parity of the tapped bits.
  function automatic logic [31:0] lfsr_n(input logic [31:0] s, input int n);
    logic [31:0] x;
    x = s;
    for (int k = 0; k < n; k++) begin
      x = (x << 1) | 32'($countones(x & TAPS) % 2);
    end
    return x;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = SEED;
    m_valid = 1'b0;
    m_lock  = 1'b0;
  endtask

  // Apply the inputs present before the edge to the model, then wait past the edge.
  task automatic tick();
    logic [31:0] nxt;
    logic        took;
    took = en_i && m_valid && ready_i;
    if (load_i)    nxt = seed_i;
    else if (took) nxt = lfsr_n(m_state, 1);
    else           nxt = m_state;
    m_lock  = (load_i || took) && (nxt == 32'd0);
    m_state = m_lock ? SEED : nxt;
    m_valid = en_i;
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".data"},  64'(data_o),   64'(m_state));
    check({tag, ".valid"}, 64'(valid_o),  64'(m_valid));
    check({tag, ".lock"},  64'(lockup_o), 64'(m_lock));
  endtask

  initial begin
    int r;
    reset_i = 1'b1;
    en_i = 1'b0; load_i = 1'b0; ready_i = 1'b0; seed_i = '0;
    en4 = 1'b0; load4 = 1'b0; ready4 = 1'b0; seed4 = '0;
    model_reset();
    #3;
    check("rst.data",  64'(data_o),   64'h0014_4FDE);
    check("rst.valid", 64'(valid_o),  64'd0);
    check("rst.lock",  64'(lockup_o), 64'd0);
    check("rst.data4", 64'(data4),    64'h0014_4FDE);
    @(negedge clk_i);
    reset_i = 1'b0;

    // Scenario 1/2: first word, backpressure hold, then one advance per cycle.
    en_i = 1'b1; ready_i = 1'b0;
    tick();
    check("s1.data",  64'(data_o),  64'h0014_4FDE);
    check("s1.valid", 64'(valid_o), 64'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("s2.hold", 64'(data_o),  64'h0014_4FDE);
      check("s2.valid", 64'(valid_o), 64'd1);
    end
    ready_i = 1'b1;
    tick();
    check("s1.accept", 64'(data_o), 64'h0028_9FBD);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_model("s2.run");
    end

    // Scenario 3: loading zero recovers to SEED with a single lock-up pulse.
    load_i = 1'b1; seed_i = 32'd0;
    tick();
    check("s3.data", 64'(data_o),   64'h0014_4FDE);
    check("s3.lock", 64'(lockup_o), 64'd1);
    load_i = 1'b0; ready_i = 1'b0;
    tick();
    check("s3.lock_off", 64'(lockup_o), 64'd0);

    // Scenario 4: load during a handshake takes the seed without advancing.
    ready_i = 1'b1; load_i = 1'b1; seed_i = 32'hDEAD_BEEF;
    tick();
    check("s4.data", 64'(data_o), 64'hDEAD_BEEF);
    load_i = 1'b0; ready_i = 1'b0;
    tick();
    check("s4.held", 64'(data_o), 64'hDEAD_BEEF);

    // Advance into zero: top bit alone is untapped, so the next shift is all-zero.
    load_i = 1'b1; seed_i = 32'h8000_0000;
    tick();
    check("lz.loaded", 64'(data_o),   64'h8000_0000);
    check("lz.nolock", 64'(lockup_o), 64'd0);
    load_i = 1'b0; ready_i = 1'b1;
    tick();
    check("lz.data", 64'(data_o),   64'h0014_4FDE);
    check("lz.lock", 64'(lockup_o), 64'd1);

    // Load while disabled still takes effect; valid drops.
    en_i = 1'b0; load_i = 1'b1; seed_i = 32'h1234_5678;
    tick();
    check("dis.data",  64'(data_o),  64'h1234_5678);
    check("dis.valid", 64'(valid_o), 64'd0);
    load_i = 1'b0;
    tick();
    check("dis.hold", 64'(data_o), 64'h1234_5678);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      en_i    = ($urandom_range(0, 3) != 0);
      ready_i = $urandom_range(0, 1) == 1;
      load_i  = ($urandom_range(0, 19) == 0);
      r = int'($urandom_range(0, 3));
      seed_i  = (r == 0) ? 32'd0 : (r == 1) ? 32'h8000_0000 : $urandom;
      tick();
      check_model("rand");
    end

    // Scenario 6: asynchronous reset between edges, then restart.
    en_i = 1'b1; ready_i = 1'b1; load_i = 1'b0;
    tick();
    tick();
    #2;
    reset_i = 1'b1;
    #1;
    check("s6.data",  64'(data_o),   64'h0014_4FDE);
    check("s6.valid", 64'(valid_o),  64'd0);
    check("s6.lock",  64'(lockup_o), 64'd0);
    @(negedge clk_i);
    reset_i = 1'b0;
    model_reset();
    tick();
    check("s6.first", 64'(data_o),  64'h0014_4FDE);
    check("s6.valid1", 64'(valid_o), 64'd1);
    tick();
    check("s6.second", 64'(data_o), 64'h0028_9FBD);

    // Scenario 5: every STEP=4 word equals every 4th single-step word.
    q[0] = SEED;
    for (int i = 1; i <= 4000; i++) q[i] = lfsr_n(q[i-1], 1);
    en4 = 1'b1; ready4 = 1'b1;
    @(posedge clk_i);
    #1;
    check("s5.valid", 64'(valid4), 64'd1);
    for (int k = 0; k < 1000; k++) begin
      check("s5.word", 64'(data4), 64'(q[4*k]));
      @(posedge clk_i);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
